// File: rtl/ex_mem_stage.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | ex_mem_stage : EX/MEM pipeline register with branch/JAL resolution,    |
// |                PC redirect, wrong-path squash and branch statistics.   |
// | Revision     : 1.0                                                     |
// +------------------------------------------------------------------------+
module ex_mem_stage #(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 4,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      ex_valid,
   output logic                      ex_ready,
   input  logic [DATA_WIDTH-1:0]     alu_out,
   input  logic                      alu_compare,
   input  logic                      ex_is_branch,
   input  logic                      ex_is_jal,
   input  logic [DATA_WIDTH-1:0]     ex_pc_plus4,
   input  logic [DATA_WIDTH-1:0]     ex_imm,
   input  logic [DATA_WIDTH-1:0]     ex_jal_base,
   input  logic [DATA_WIDTH-1:0]     ex_store_data,
   input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
   input  logic                      ex_reg_we,
   input  logic                      ex_mem_we,
   input  logic                      ex_mem_re,
   input  logic                      mem_ready,
   output logic                      mem_valid,
   output logic [DATA_WIDTH-1:0]     mem_result,
   output logic [DATA_WIDTH-1:0]     mem_store_data,
   output logic [REG_ADDR_WIDTH-1:0] mem_rd,
   output logic                      mem_reg_we,
   output logic                      mem_mem_we,
   output logic                      mem_mem_re,
   output logic                      redirect_valid,
   output logic [DATA_WIDTH-1:0]     redirect_pc,
   output logic [CNT_WIDTH-1:0]      br_total,
   output logic [CNT_WIDTH-1:0]      br_taken
);

   logic                      r_mem_valid;
   logic [DATA_WIDTH-1:0]     r_mem_result;
   logic [DATA_WIDTH-1:0]     r_mem_store_data;
   logic [REG_ADDR_WIDTH-1:0] r_mem_rd;
   logic                      r_mem_reg_we;
   logic                      r_mem_mem_we;
   logic                      r_mem_mem_re;
   logic                      r_redirect_valid;
   logic [DATA_WIDTH-1:0]     r_redirect_pc;
   logic [CNT_WIDTH-1:0]      r_br_total;
   logic [CNT_WIDTH-1:0]      r_br_taken;
   logic                      r_shadow;

   logic                      w_ready;
   logic                      w_accept;
   logic                      w_live;
   logic                      w_cond_branch;
   logic                      w_taken;
   logic                      w_redirect;
   logic                      w_shadow_clear;
   logic [DATA_WIDTH-1:0]     w_base;
   logic [DATA_WIDTH-1:0]     w_target;
   logic [DATA_WIDTH-1:0]     w_result;

   assign w_ready        = !r_mem_valid || mem_ready;
   assign w_accept       = ex_valid && w_ready;
   // The slot directly behind a redirect is wrong-path and is squashed.
   assign w_live         = w_accept && !r_shadow;
   assign w_cond_branch  = ex_is_branch && !ex_is_jal;
   assign w_taken        = w_cond_branch && alu_compare;
   assign w_redirect     = w_live && (ex_is_jal || w_taken);
   assign w_shadow_clear = r_shadow && (w_accept || !ex_valid);

   assign w_base   = ex_is_jal ? ex_jal_base : ex_pc_plus4;
   assign w_target = w_base + (ex_imm << 2);
   assign w_result = ex_is_jal ? ex_pc_plus4 : alu_out;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_mem_valid      <= 1'b0;
         r_mem_result     <= '0;
         r_mem_store_data <= '0;
         r_mem_rd         <= '0;
         r_mem_reg_we     <= 1'b0;
         r_mem_mem_we     <= 1'b0;
         r_mem_mem_re     <= 1'b0;
      end else if (w_ready) begin
         if (w_live) begin
            r_mem_valid      <= 1'b1;
            r_mem_result     <= w_result;
            r_mem_store_data <= ex_store_data;
            r_mem_rd         <= ex_rd;
            r_mem_reg_we     <= ex_reg_we;
            r_mem_mem_we     <= ex_mem_we;
            r_mem_mem_re     <= ex_mem_re;
         end else begin
            r_mem_valid  <= 1'b0;
            r_mem_reg_we <= 1'b0;
            r_mem_mem_we <= 1'b0;
            r_mem_mem_re <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_redirect_valid <= 1'b0;
         r_redirect_pc    <= '0;
         r_shadow         <= 1'b0;
      end else begin
         r_redirect_valid <= w_redirect;
         if (w_redirect) begin
            r_redirect_pc <= {w_target[DATA_WIDTH-1:2], 2'b00};
            r_shadow      <= 1'b1;
         end else if (w_shadow_clear) begin
            r_shadow      <= 1'b0;
         end
      end
   end

   // Saturating statistics; JAL and squashed slots never count.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_br_total <= '0;
         r_br_taken <= '0;
      end else if (w_live && w_cond_branch) begin
         if (r_br_total != {CNT_WIDTH{1'b1}}) begin
            r_br_total <= r_br_total + CNT_WIDTH'(1);
         end
         if (alu_compare && (r_br_taken != {CNT_WIDTH{1'b1}})) begin
            r_br_taken <= r_br_taken + CNT_WIDTH'(1);
         end
      end
   end

   assign ex_ready       = w_ready;
   assign mem_valid      = r_mem_valid;
   assign mem_result     = r_mem_result;
   assign mem_store_data = r_mem_store_data;
   assign mem_rd         = r_mem_rd;
   assign mem_reg_we     = r_mem_reg_we;
   assign mem_mem_we     = r_mem_mem_we;
   assign mem_mem_re     = r_mem_mem_re;
   assign redirect_valid = r_redirect_valid;
   assign redirect_pc    = r_redirect_pc;
   assign br_total       = r_br_total;
   assign br_taken       = r_br_taken;

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_stage.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_ex_mem_stage : directed and randomized bench for ex_mem_stage.      |
// | Revision        : 1.0                                                  |
// +------------------------------------------------------------------------+
module tb_ex_mem_stage;

   localparam int DW = 32;
   localparam int RW = 4;
   localparam int CW = 4;
   localparam int CMAX = 15;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          ex_valid = 1'b0;
   logic          ex_ready;
   logic [DW-1:0] alu_out = '0;
   logic          alu_compare = 1'b0;
   logic          ex_is_branch = 1'b0;
   logic          ex_is_jal = 1'b0;
   logic [DW-1:0] ex_pc_plus4 = '0;
   logic [DW-1:0] ex_imm = '0;
   logic [DW-1:0] ex_jal_base = '0;
   logic [DW-1:0] ex_store_data = '0;
   logic [RW-1:0] ex_rd = '0;
   logic          ex_reg_we = 1'b0;
   logic          ex_mem_we = 1'b0;
   logic          ex_mem_re = 1'b0;
   logic          mem_ready = 1'b1;
   logic          mem_valid;
   logic [DW-1:0] mem_result;
   logic [DW-1:0] mem_store_data;
   logic [RW-1:0] mem_rd;
   logic          mem_reg_we;
   logic          mem_mem_we;
   logic          mem_mem_re;
   logic          redirect_valid;
   logic [DW-1:0] redirect_pc;
   logic [CW-1:0] br_total;
   logic [CW-1:0] br_taken;

   int checks = 0;
   int errors = 0;

   ex_mem_stage #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(RW), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready),
      .alu_out(alu_out), .alu_compare(alu_compare), .ex_is_branch(ex_is_branch),
      .ex_is_jal(ex_is_jal), .ex_pc_plus4(ex_pc_plus4), .ex_imm(ex_imm),
      .ex_jal_base(ex_jal_base), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
      .ex_reg_we(ex_reg_we), .ex_mem_we(ex_mem_we), .ex_mem_re(ex_mem_re),
      .mem_ready(mem_ready), .mem_valid(mem_valid), .mem_result(mem_result),
      .mem_store_data(mem_store_data), .mem_rd(mem_rd), .mem_reg_we(mem_reg_we),
      .mem_mem_we(mem_mem_we), .mem_mem_re(mem_mem_re),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .br_total(br_total), .br_taken(br_taken)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: what the stage should hold after each edge.
   logic          m_valid = 0, m_rwe = 0, m_mwe = 0, m_mre = 0, m_rv = 0, m_shadow = 0;
   logic [DW-1:0] m_result = 0, m_store = 0, m_rpc = 0;
   logic [RW-1:0] m_rd = 0;
   int            m_tot = 0, m_tak = 0;

   always @(posedge clk) begin
      bit can_take, take, redir;
      logic [DW-1:0] tgt;
      redir = 0;
      tgt   = '0;
      if (!rst_n) begin
         m_valid = 0; m_rwe = 0; m_mwe = 0; m_mre = 0; m_rv = 0; m_shadow = 0;
         m_result = 0; m_store = 0; m_rpc = 0; m_rd = 0; m_tot = 0; m_tak = 0;
      end else begin
         can_take = !m_valid || mem_ready;
         take     = ex_valid && can_take;
         if (take && m_shadow) begin
            m_valid = 0; m_rwe = 0; m_mwe = 0; m_mre = 0;
            m_shadow = 0;
         end else if (take) begin
            m_valid = 1; m_rwe = ex_reg_we; m_mwe = ex_mem_we; m_mre = ex_mem_re;
            m_rd = ex_rd; m_store = ex_store_data;
            if (ex_is_jal) begin
               m_result = ex_pc_plus4;
               redir    = 1;
               tgt      = ex_jal_base + ex_imm * 4;
            end else begin
               m_result = alu_out;
               if (ex_is_branch) begin
                  m_tot = (m_tot < CMAX) ? m_tot + 1 : CMAX;
                  if (alu_compare) begin
                     m_tak = (m_tak < CMAX) ? m_tak + 1 : CMAX;
                     redir = 1;
                     tgt   = ex_pc_plus4 + ex_imm * 4;
                  end
               end
            end
            if (redir) m_shadow = 1;
         end else begin
            if (can_take) begin
               m_valid = 0; m_rwe = 0; m_mwe = 0; m_mre = 0;
            end
            if (!ex_valid) m_shadow = 0;
         end
         m_rv = redir;
         if (redir) m_rpc = tgt & ~32'h3;
      end
      #1;
      chk("ex_ready", DW'(ex_ready), DW'(!m_valid || mem_ready));
      chk("mem_valid", DW'(mem_valid), DW'(m_valid));
      chk("enables", DW'({mem_reg_we, mem_mem_we, mem_mem_re}), DW'({m_rwe, m_mwe, m_mre}));
      if (m_valid) begin
         chk("mem_result", mem_result, m_result);
         chk("mem_store_data", mem_store_data, m_store);
         chk("mem_rd", DW'(mem_rd), DW'(m_rd));
      end
      chk("redirect_valid", DW'(redirect_valid), DW'(m_rv));
      chk("redirect_pc", redirect_pc, m_rpc);
      chk("br_total", DW'(br_total), DW'(m_tot));
      chk("br_taken", DW'(br_taken), DW'(m_tak));
   end

   task automatic idle();
      ex_valid = 0; ex_is_branch = 0; ex_is_jal = 0; alu_compare = 0;
      ex_reg_we = 0; ex_mem_we = 0; ex_mem_re = 0;
   endtask

   task automatic instr(input logic [DW-1:0] alu, input logic [RW-1:0] rd);
      idle();
      ex_valid = 1; alu_out = alu; ex_rd = rd; ex_reg_we = 1;
   endtask

   task automatic branch(input logic cmp, input logic [DW-1:0] pc4, input logic [DW-1:0] imm);
      idle();
      ex_valid = 1; ex_is_branch = 1; alu_compare = cmp;
      ex_pc_plus4 = pc4; ex_imm = imm; alu_out = 32'hB0;
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   initial begin
      // Reset with a valid instruction presented
      rst_n = 0;
      instr(32'h55, 4'd9);
      repeat (2) begin
         tick();
         chk("rst mem_valid", DW'(mem_valid), 0);
         chk("rst ex_ready", DW'(ex_ready), 1);
         chk("rst redirect", DW'(redirect_valid), 0);
         chk("rst br_total", DW'(br_total), 0);
      end
      @(negedge clk); rst_n = 1; instr(32'h7, 4'd3);
      tick();
      chk("add valid", DW'(mem_valid), 1);
      chk("add result", mem_result, 32'h7);
      chk("add rd", DW'(mem_rd), 3);
      chk("add redirect", DW'(redirect_valid), 0);

      @(negedge clk); branch(1'b1, 32'h100, 32'hFFFF_FFFE);
      tick();
      chk("br redirect", DW'(redirect_valid), 1);
      chk("br pc", redirect_pc, 32'h0F8);
      chk("br total", DW'(br_total), 1);
      chk("br taken", DW'(br_taken), 1);
      @(negedge clk); instr(32'h5, 4'd4);
      tick();
      chk("squash valid", DW'(mem_valid), 0);
      chk("squash we", DW'(mem_reg_we), 0);
      chk("squash redirect", DW'(redirect_valid), 0);
      @(negedge clk); instr(32'h9, 4'd5);
      tick();
      chk("third valid", DW'(mem_valid), 1);
      chk("third result", mem_result, 32'h9);

      @(negedge clk); idle();
      ex_valid = 1; ex_is_jal = 1; ex_jal_base = 32'h2001; ex_imm = 32'h4; ex_pc_plus4 = 32'h40;
      tick();
      chk("jal pc", redirect_pc, 32'h2010);
      chk("jal link", mem_result, 32'h40);
      chk("jal redirect", DW'(redirect_valid), 1);
      @(negedge clk); instr(32'h77, 4'd6); mem_ready = 0;
      repeat (3) begin
         tick();
         chk("stall valid", DW'(mem_valid), 1);
         chk("stall result", mem_result, 32'h40);
         chk("stall ready", DW'(ex_ready), 0);
      end
      @(negedge clk); mem_ready = 1;
      tick();
      chk("jal squash", DW'(mem_valid), 0);

      @(negedge clk); branch(1'b1, 32'h200, 32'h10);
      tick();
      @(negedge clk); idle();
      tick();
      @(negedge clk); instr(32'h11, 4'd7);
      tick();
      chk("bubble live", DW'(mem_valid), 1);
      chk("bubble result", mem_result, 32'h11);

      for (int i = 0; i < 17; i++) begin
         @(negedge clk); branch(1'b1, 32'h300, 32'h1);
         tick();
         @(negedge clk); idle();
         tick();
      end
      chk("sat total", DW'(br_total), 32'hF);
      chk("sat taken", DW'(br_taken), 32'hF);
      @(negedge clk); branch(1'b0, 32'h400, 32'h8);
      tick();
      chk("nt redirect", DW'(redirect_valid), 0);
      chk("nt total", DW'(br_total), 32'hF);
      chk("nt valid", DW'(mem_valid), 1);
      chk("nt result", mem_result, 32'hB0);

      // Randomized phase, checked against the model every cycle
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         rst_n         = ($urandom_range(0, 149) != 0);
         ex_valid      = ($urandom_range(0, 9) < 7);
         mem_ready     = ($urandom_range(0, 3) != 0);
         ex_is_branch  = ($urandom_range(0, 2) == 0);
         ex_is_jal     = ($urandom_range(0, 7) == 0);
         alu_compare   = $urandom_range(0, 1);
         alu_out       = $urandom;
         ex_pc_plus4   = $urandom;
         ex_imm        = $urandom;
         ex_jal_base   = $urandom;
         ex_store_data = $urandom;
         ex_rd         = RW'($urandom);
         ex_reg_we     = $urandom_range(0, 1);
         ex_mem_we     = $urandom_range(0, 1);
         ex_mem_re     = $urandom_range(0, 1);
      end
      @(negedge clk); idle(); rst_n = 1;
      tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
